// File: rtl/cpci_reprogrammer.sv
// Slave-serial reprogramming master: drives enable/PROG_B, waits for INIT_B,
// shifts bytes MSB-first on DIN against the target CCLK, then waits for DONE.
`timescale 1ns/1ps
module cpci_reprogrammer #(
    parameter int unsigned PROG_B_CYCLES = 32,
    parameter int unsigned INIT_TIMEOUT  = 4096,
    parameter int unsigned DONE_TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       cpci_rp_en,
    output logic       cpci_rp_prog_b,
    output logic       cpci_rp_din,
    input  logic       cpci_rp_cclk,
    input  logic       cpci_rp_init_b,
    input  logic       cpci_rp_done,
    output logic       busy,
    output logic       prog_done,
    output logic [2:0] prog_error
);

    localparam logic [15:0] PROG_LAST_C = 16'(PROG_B_CYCLES - 32'd1);
    localparam logic [15:0] INIT_LAST_C = 16'(INIT_TIMEOUT - 32'd1);
    localparam logic [15:0] DONE_LAST_C = 16'(DONE_TIMEOUT - 32'd1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_INIT  = 3'd1;
    localparam logic [2:0] ERR_UNDER = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;
    localparam logic [2:0] ERR_DONE  = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ENABLE, ST_PROG_LOW, ST_WAIT_INIT, ST_WAIT_EDGE,
        ST_SHIFT, ST_WAIT_DONE, ST_DONE, ST_ERROR
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  cclk_sync_r;
    logic [1:0]  init_sync_r, done_sync_r;
    logic        cclk_rise_s, cclk_fall_s, init_hi_s, done_hi_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  shift_r, shift_s, hold_r, hold_s;
    logic        cur_last_r, cur_last_s, hold_valid_r, hold_valid_s;
    logic        hold_last_r, hold_last_s, last_seen_r, last_seen_s;
    logic        load_s, clear_s, data_phase_s;
    logic        ready_r, ready_s, en_r, en_s, prog_b_r, prog_b_s;
    logic        din_r, din_s, busy_r, busy_s, prog_done_r, prog_done_s;
    logic [2:0]  err_r, err_s;

    assign cclk_rise_s = cclk_sync_r[1] & ~cclk_sync_r[2];
    assign cclk_fall_s = ~cclk_sync_r[1] & cclk_sync_r[2];
    assign init_hi_s   = init_sync_r[1];
    assign done_hi_s   = done_sync_r[1];

    // Synchronize the asynchronous target pins; CCLK gets an extra edge-detect stage
    always_ff @(posedge clk) begin
        if (reset) begin
            cclk_sync_r <= 3'b000;
            init_sync_r <= 2'b00;
            done_sync_r <= 2'b00;
        end else begin
            cclk_sync_r <= {cclk_sync_r[1:0], cpci_rp_cclk};
            init_sync_r <= {init_sync_r[0], cpci_rp_init_b};
            done_sync_r <= {done_sync_r[0], cpci_rp_done};
        end
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        cur_last_s   = cur_last_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        hold_last_s  = hold_last_r;
        last_seen_s  = last_seen_r;
        din_s        = din_r;
        err_s        = err_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;

        if (data_valid && ready_r) begin
            hold_s       = data_in;
            hold_valid_s = 1'b1;
            hold_last_s  = data_last;
            last_seen_s  = last_seen_r | data_last;
        end else begin
            hold_s = hold_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin state_s = ST_ENABLE; clear_s = 1'b1; end
                else       begin state_s = ST_IDLE; end
            end
            ST_ENABLE: state_s = ST_PROG_LOW;
            ST_PROG_LOW: begin
                if (cnt_r == PROG_LAST_C) begin state_s = ST_WAIT_INIT; end
                else                      begin state_s = ST_PROG_LOW; end
            end
            ST_WAIT_INIT: begin
                if (init_hi_s)                 begin state_s = ST_WAIT_EDGE; end
                else if (cnt_r == INIT_LAST_C) begin state_s = ST_ERROR; err_s = ERR_INIT; end
                else                           begin state_s = ST_WAIT_INIT; end
            end
            ST_WAIT_EDGE: begin
                if (cclk_fall_s && hold_valid_r) begin state_s = ST_SHIFT; load_s = 1'b1; end
                else if (cclk_fall_s)            begin state_s = ST_ERROR; err_s = ERR_UNDER; end
                else                             begin state_s = ST_WAIT_EDGE; end
            end
            ST_SHIFT: begin
                if (!init_hi_s) begin
                    state_s = ST_ERROR;
                    err_s   = ERR_CRC;
                end else if (cclk_rise_s && (bit_cnt_r == 3'd7) && cur_last_r) begin
                    state_s = ST_WAIT_DONE;
                end else if (cclk_fall_s && (bit_cnt_r != 3'd7)) begin
                    shift_s   = {shift_r[6:0], 1'b0};
                    din_s     = shift_r[6];
                    bit_cnt_s = bit_cnt_r + 3'd1;
                end else if (cclk_fall_s && hold_valid_r) begin
                    load_s = 1'b1;
                end else if (cclk_fall_s && !cur_last_r) begin
                    state_s = ST_ERROR;
                    err_s   = ERR_UNDER;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_WAIT_DONE: begin
                if (!init_hi_s)                begin state_s = ST_ERROR; err_s = ERR_CRC; end
                else if (done_hi_s)            begin state_s = ST_DONE; end
                else if (cnt_r == DONE_LAST_C) begin state_s = ST_ERROR; err_s = ERR_DONE; end
                else                           begin state_s = ST_WAIT_DONE; end
            end
            ST_DONE: begin
                if (start) begin state_s = ST_ENABLE; clear_s = 1'b1; end
                else       begin state_s = ST_DONE; end
            end
            ST_ERROR: begin
                // enable is already high, so a restart skips ENABLE
                if (start) begin state_s = ST_PROG_LOW; clear_s = 1'b1; end
                else       begin state_s = ST_ERROR; end
            end
            default: state_s = ST_IDLE;
        endcase

        if (load_s) begin
            shift_s      = hold_r;
            din_s        = hold_r[7];
            cur_last_s   = hold_last_r;
            bit_cnt_s    = 3'd0;
            hold_valid_s = 1'b0;
        end else begin
            shift_s = shift_s;
        end

        if (clear_s) begin
            err_s        = ERR_NONE;
            hold_valid_s = 1'b0;
            last_seen_s  = 1'b0;
            cur_last_s   = 1'b0;
            bit_cnt_s    = 3'd0;
            din_s        = 1'b0;
        end else begin
            err_s = err_s;
        end

        if (state_s != state_r)      cnt_s = 16'd0;
        else if (cnt_r != 16'hFFFF)  cnt_s = cnt_r + 16'd1;
        else                         cnt_s = cnt_r;

        data_phase_s = (state_s == ST_PROG_LOW) || (state_s == ST_WAIT_INIT) ||
                       (state_s == ST_WAIT_EDGE) || (state_s == ST_SHIFT);
        ready_s      = data_phase_s && !hold_valid_s && !last_seen_s;
        en_s         = (state_s != ST_IDLE) && !((state_r == ST_DONE) && (state_s == ST_DONE));
        prog_b_s     = (state_s != ST_PROG_LOW);
        busy_s       = !((state_s == ST_IDLE) || (state_s == ST_DONE) || (state_s == ST_ERROR));
        prog_done_s  = (state_s == ST_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            cur_last_r   <= 1'b0;
            hold_r       <= 8'd0;
            hold_valid_r <= 1'b0;
            hold_last_r  <= 1'b0;
            last_seen_r  <= 1'b0;
            ready_r      <= 1'b0;
            en_r         <= 1'b0;
            prog_b_r     <= 1'b1;
            din_r        <= 1'b0;
            busy_r       <= 1'b0;
            prog_done_r  <= 1'b0;
            err_r        <= 3'd0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            cur_last_r   <= cur_last_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            hold_last_r  <= hold_last_s;
            last_seen_r  <= last_seen_s;
            ready_r      <= ready_s;
            en_r         <= en_s;
            prog_b_r     <= prog_b_s;
            din_r        <= din_s;
            busy_r       <= busy_s;
            prog_done_r  <= prog_done_s;
            err_r        <= err_s;
        end
    end

    assign data_ready     = ready_r;
    assign cpci_rp_en     = en_r;
    assign cpci_rp_prog_b = prog_b_r;
    assign cpci_rp_din    = din_r;
    assign busy           = busy_r;
    assign prog_done      = prog_done_r;
    assign prog_error     = err_r;

endmodule

// File: tb/tb_cpci_reprogrammer.sv
// Bench for cpci_reprogrammer: byte feeder, CCLK-driving target model that
// reassembles bytes from DIN, and directed scenarios with randomized data.
`timescale 1ns/1ps
module tb_cpci_reprogrammer;

    logic       clk, reset, start;
    logic [7:0] data_in;
    logic       data_valid, data_last, data_ready;
    logic       cpci_rp_en, cpci_rp_prog_b, cpci_rp_din;
    logic       cpci_rp_cclk, cpci_rp_init_b, cpci_rp_done;
    logic       busy, prog_done;
    logic [2:0] prog_error;

    int checks = 0;
    int errors = 0;

    logic [8:0] feed_mem [0:63];
    logic [7:0] exp_mem  [0:63];
    int         feed_len = 0;
    int         run_id   = 0;
    int         stall_at = -1;
    int         fed_cnt  = 0;
    logic       cclk_en  = 1'b0;
    logic [7:0] rx_q [$];
    int         rx_base  = 0;

    cpci_reprogrammer dut (
        .clk(clk), .reset(reset), .start(start),
        .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
        .data_ready(data_ready), .cpci_rp_en(cpci_rp_en),
        .cpci_rp_prog_b(cpci_rp_prog_b), .cpci_rp_din(cpci_rp_din),
        .cpci_rp_cclk(cpci_rp_cclk), .cpci_rp_init_b(cpci_rp_init_b),
        .cpci_rp_done(cpci_rp_done), .busy(busy), .prog_done(prog_done),
        .prog_error(prog_error)
    );

    initial begin
        clk = 1'b0;
        forever #8 clk = ~clk;
    end

    // Byte source: presents feed_mem in order, withholding index stall_at
    initial begin : feeder
        logic acc;
        int   my_run, idx;
        data_valid = 1'b0; data_in = 8'h00; data_last = 1'b0;
        my_run = 0; idx = 0;
        forever begin
            @(negedge clk);
            acc = data_valid && data_ready;
            @(posedge clk);
            #1;
            if (my_run != run_id) begin my_run = run_id; idx = 0; end
            else if (acc) idx++;
            fed_cnt = idx;
            if (idx < feed_len && idx != stall_at) begin
                data_valid = 1'b1;
                {data_last, data_in} = feed_mem[idx];
            end else begin
                data_valid = 1'b0; data_last = 1'b0; data_in = 8'h00;
            end
        end
    end

    // Target model: CCLK idles high, DIN sampled MSB-first on each rising edge
    initial begin : target
        int h, bits;
        logic [7:0] sr;
        cpci_rp_cclk = 1'b1; bits = 0; sr = 8'h00;
        forever begin
            if (cclk_en) begin
                h = $urandom_range(110, 70);
                cpci_rp_cclk = 1'b0;
                #(h);
                cpci_rp_cclk = 1'b1;
                sr = {sr[6:0], cpci_rp_din};
                bits++;
                if (bits == 8) begin rx_q.push_back(sr); bits = 0; end
                #(h);
            end else begin
                bits = 0;
                #4;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_en",      32'(cpci_rp_en),     32'd0);
        chk("rst_prog_b",  32'(cpci_rp_prog_b), 32'd1);
        chk("rst_din",     32'(cpci_rp_din),    32'd0);
        chk("rst_ready",   32'(data_ready),     32'd0);
        chk("rst_busy",    32'(busy),           32'd0);
        chk("rst_done",    32'(prog_done),      32'd0);
        chk("rst_error",   32'(prog_error),     32'd0);
    endtask

    task automatic prep(input int n, input bit rnd, input bit extra);
        for (int i = 0; i < n; i++) begin
            exp_mem[i]  = rnd ? 8'($urandom_range(255, 0)) : 8'(i);
            feed_mem[i] = {(i == n - 1), exp_mem[i]};
        end
        feed_len = n;
        if (extra) begin feed_mem[n] = {1'b0, 8'hAA}; feed_len = n + 1; end
        run_id++;
        rx_base = rx_q.size();
        cpci_rp_done = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Called on a negedge: measures PROG_B low width, then runs the INIT_B handshake
    task automatic init_phase(input bit release_init);
        int n;
        n = 0;
        while (cpci_rp_prog_b !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("prog_b_fall", 32'(cpci_rp_prog_b), 32'd0);
        cpci_rp_init_b = 1'b0;
        n = 0;
        while (cpci_rp_prog_b === 1'b0 && n < 1000) begin n++; @(negedge clk); end
        chk("prog_b_width", n, 32'd32);
        if (release_init) begin
            tick(20); cpci_rp_init_b = 1'b1; tick(10); cclk_en = 1'b1;
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < rx_base + n && k < 40000) begin @(negedge clk); k++; end
        chk(tag, 32'(rx_q.size() >= rx_base + n), 32'd1);
    endtask

    task automatic cmp_rx(input int n);
        for (int i = 0; i < n; i++) begin
            if (rx_base + i < rx_q.size()) chk("rx_byte", 32'(rx_q[rx_base + i]), 32'(exp_mem[i]));
            else                           chk("rx_missing", i, n);
        end
    endtask

    task automatic finish_ok(input int n);
        int k;
        wait_rx(n, "rx_complete");
        cclk_en = 1'b0;
        cmp_rx(n);
        chk("busy_wait_done", 32'(busy), 32'd1);
        tick(20);
        cpci_rp_done = 1'b1;
        k = 0;
        while (prog_done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("prog_done",        32'(prog_done),  32'd1);
        chk("en_at_done_entry", 32'(cpci_rp_en), 32'd1);
        chk("error_after_done", 32'(prog_error), 32'd0);
        chk("busy_after_done",  32'(busy),       32'd0);
        @(negedge clk);
        chk("en_after_done",    32'(cpci_rp_en), 32'd0);
        chk("ready_after_done", 32'(data_ready), 32'd0);
    endtask

    initial begin : main
        int n, k;
        reset = 1'b1; start = 1'b0; cpci_rp_init_b = 1'b1; cpci_rp_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1 reset = 1'b0;
        tick(3);

        // Nominal 0x00..0x0F, with one byte offered after the last
        prep(16, 1'b0, 1'b1);
        start_pulse();
        @(negedge clk);
        chk("en_rise",        32'(cpci_rp_en),     32'd1);
        chk("prog_b_pre_low", 32'(cpci_rp_prog_b), 32'd1);
        chk("busy_start",     32'(busy),           32'd1);
        init_phase(1'b1);
        finish_ok(16);
        chk("extra_not_taken", fed_cnt, 32'd16);

        // Random bytes, restart from DONE
        tick(20);
        n = $urandom_range(12, 4);
        prep(n, 1'b1, 1'b0);
        start_pulse();
        @(negedge clk);
        chk("en_rise_from_done", 32'(cpci_rp_en), 32'd1);
        init_phase(1'b1);
        finish_ok(n);

        // Underrun: byte 5 withheld
        tick(20);
        prep(10, 1'b1, 1'b0);
        stall_at = 5;
        start_pulse();
        @(negedge clk);
        chk("done_cleared", 32'(prog_done), 32'd0);
        init_phase(1'b1);
        k = 0;
        while (prog_error === 3'd0 && k < 40000) begin @(negedge clk); k++; end
        chk("underrun_code",  32'(prog_error), 32'd2);
        chk("underrun_busy",  32'(busy),       32'd0);
        chk("underrun_ready", 32'(data_ready), 32'd0);
        cmp_rx(5);
        cclk_en = 1'b0; stall_at = -1;
        tick(20);

        // INIT timeout, restarting straight from ERROR into PROG_LOW
        prep(4, 1'b1, 1'b0);
        start_pulse();
        @(negedge clk);
        chk("restart_prog_b", 32'(cpci_rp_prog_b), 32'd0);
        chk("restart_en",     32'(cpci_rp_en),     32'd1);
        chk("restart_clear",  32'(prog_error),     32'd0);
        init_phase(1'b0);
        n = 0;
        while (prog_error !== 3'd1 && n < 5000) begin @(negedge clk); n++; end
        chk("init_timeout_cycles", n, 32'd4096);
        chk("init_timeout_code",   32'(prog_error), 32'd1);
        chk("init_timeout_busy",   32'(busy),       32'd0);
        chk("init_timeout_en",     32'(cpci_rp_en), 32'd1);

        // INIT_B pulled low mid-stream
        prep(8, 1'b1, 1'b0);
        start_pulse();
        @(negedge clk);
        init_phase(1'b1);
        wait_rx(3, "rx_before_crc");
        cpci_rp_init_b = 1'b0;
        k = 0;
        while (prog_error === 3'd0 && k < 100) begin @(negedge clk); k++; end
        chk("crc_code", 32'(prog_error), 32'd3);
        chk("crc_busy", 32'(busy),       32'd0);
        cclk_en = 1'b0;
        tick(20);

        // DONE never rises
        prep(6, 1'b1, 1'b0);
        start_pulse();
        @(negedge clk);
        init_phase(1'b1);
        wait_rx(6, "rx_before_done_to");
        cclk_en = 1'b0;
        cmp_rx(6);
        n = 0;
        while (prog_error !== 3'd4 && n < 70000) begin @(negedge clk); n++; end
        chk("done_timeout_code",   32'(prog_error), 32'd4);
        chk("done_timeout_window", 32'(n >= 65530 && n <= 65545), 32'd1);
        chk("done_timeout_busy",   32'(busy), 32'd0);
        tick(20);

        // Reset while byte 7 is shifting
        prep(12, 1'b1, 1'b0);
        start_pulse();
        @(negedge clk);
        init_phase(1'b1);
        wait_rx(7, "rx_before_reset");
        chk("busy_in_shift", 32'(busy), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        cclk_en = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        tick(20);

        // Clean run after reset
        n = $urandom_range(10, 3);
        prep(n, 1'b1, 1'b0);
        start_pulse();
        @(negedge clk);
        chk("en_rise_after_reset", 32'(cpci_rp_en), 32'd1);
        init_phase(1'b1);
        finish_ok(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
